hash_round_ctrl: RTL and testbench
==================================

// Module: hash_round_ctrl
// PURPOSE
//  Sequencer for the SHA-512 compression datapath. Accepts 1024-bit message blocks over a
//  valid/ready handshake and drives the round index into the hash_k constant ROM. Issues
//  strobes to the W scheduler, working-variable and digest registers, then presents the
//  digest at message end. Holds no datapath state; it only sequences the datapath.
// PARAMETERS
//  ROUNDS     80  compression rounds per block (64 for a SHA-256 build)
//  MSG_WORDS  16  rounds taking W directly from the message block
//  RW         7   round index width; must satisfy 2**RW >= ROUNDS
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous, active-high reset
//  blk_valid      in   1   message block available on datapath input bus
//  blk_ready      out  1   controller can accept a block
//  blk_first      in   1   block starts a new message (qualified by accept)
//  blk_last       in   1   block ends the message (qualified by accept)
//  round          out  RW  round index to hash_k / W scheduler
//  msg_we         out  1   datapath captures the 16 message words
//  sched_sel      out  1   0: W from message, 1: W from sigma recurrence
//  dig_init       out  1   digest regs <= IV
//  st_init        out  1   working vars a..h <= digest regs
//  st_en          out  1   execute one compression round
//  dig_acc        out  1   digest regs += working vars
//  digest_valid   out  1   digest regs hold final message hash
//  digest_ready   in   1   consumer takes digest
//  busy           out  1   state != IDLE
// BEHAVIOUR
//  Reset: state IDLE, round 0, in_msg 0, every output 0 except blk_ready=1.
//  States: IDLE -> INIT -> ROUND -> ACC -> (OUT | IDLE); OUT -> IDLE.
//  IDLE: blk_ready=1. Accept = blk_valid & blk_ready.
//   On accept, in the same cycle: msg_we=1. Latch blk_last.
//   Assert dig_init=1 if blk_first | ~in_msg; set in_msg.
//   Go to INIT.
//  INIT: st_init=1 for one cycle; round=0; go to ROUND.
//  ROUND: st_en=1; sched_sel=(round>=MSG_WORDS).
//   round increments each cycle; at round==ROUNDS-1, round returns to 0 and state goes to ACC.
//  ACC: dig_acc=1 for one cycle.
//   If the latched last is set: in_msg<=0 and go to OUT; otherwise go to IDLE.
//  OUT: digest_valid=1 and held until digest_ready; on digest_valid&digest_ready go to IDLE.
//  Latency: accept at cycle T; INIT at T+1; rounds 0..ROUNDS-1 at T+2..T+ROUNDS+1;
//   ACC at T+ROUNDS+2; digest_valid from T+ROUNDS+3.
//   Next accept is possible at T+ROUNDS+3 (non-last block) or the cycle after the digest handshake.
//  round is 0 whenever state != ROUND. Strobes are mutually exclusive except msg_we/dig_init.
//  blk_valid outside IDLE is ignored; no input is sampled except at accept.
//  blk_first & blk_last on the same block is a single-block message.
//  blk_first mid-message restarts the message: dig_init=1 and prior chaining is discarded.
//  A block without blk_first after reset or after a completed message is treated as first.
//  digest_ready outside OUT is ignored.
//  rst in any state returns to reset values on the next edge; a partial block is abandoned.
// STRUCTURE
//  hash_pkg: ROUNDS_SHA512=80, ROUNDS_SHA256=64, MSG_WORDS=16, state encoding localparams
//   (IDLE=0, INIT=1, ROUND=2, ACC=3, OUT=4), 3-bit state type.
//  Sub-module hash_round_cnt: RW-bit counter with clear/enable; flags last (==ROUNDS-1)
//   and sched (>=MSG_WORDS).
//  Top: FSM plus the in_msg/last flags; round feeds hash_k externally.
// TESTING
//  1. Reset, single block with first=1,last=1 at T=10.
//     Expect msg_we & dig_init at 10, st_init at 11, st_en at 12..91 with round 0..79,
//     sched_sel rising at round 16, dig_acc at 92, digest_valid at 93.
//  2. Three-block message (first,-,last), digest_ready tied 1.
//     Expect dig_init only on block 1, three dig_acc pulses, one digest_valid pulse,
//     blk_ready=0 throughout busy.
//  3. Hold digest_ready=0 for 20 cycles in OUT.
//     Expect digest_valid held, blk_ready=0, blk_valid ignored; IDLE one cycle after
//     digest_ready=1.
//  4. Block with first=0 immediately after reset.
//     Expect dig_init=1. Second message with first=1 mid-message: dig_init=1 again.
//  5. Assert rst at round 37.
//     Next cycle: state IDLE, round=0, all strobes 0, blk_ready=1; new block then runs
//     the full 80 rounds.
//  6. ROUNDS=64 build: st_en for exactly 64 cycles, round 0..63, dig_acc at T+66.

Source files
------------

// File: rtl/hash_pkg.sv
// Shared constants and state encoding for the SHA-2 round sequencer.
package hash_pkg;

  localparam int ROUNDS_SHA512 = 80;
  localparam int ROUNDS_SHA256 = 64;
  localparam int MSG_WORDS     = 16;

  // Controller state encoding; the values are fixed so that debug
  // taps on the state register decode the same way in every build.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ROUND = 3'd2,
    ST_ACC   = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  // True when the state is one where the controller owns the datapath.
  function automatic logic state_is_busy(input state_t st);
    return (st != ST_IDLE);
  endfunction

endpackage

// File: rtl/hash_round_cnt.sv
// Round index counter for the compression loop. Flags the final round and
// the point where W switches from message words to the sigma recurrence.
module hash_round_cnt #(
  parameter int ROUNDS    = 80,
  parameter int MSG_WORDS = 16,
  parameter int RW        = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [RW-1:0] cnt,
  output logic          last,
  output logic          sched
);

  logic [RW-1:0] cnt_r;

  // Count rounds; clear has priority so the last round wraps straight to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + {{(RW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Decode round flags from the current count.
  always_comb begin
    cnt   = cnt_r;
    last  = (cnt_r == RW'(ROUNDS - 1));
    sched = (cnt_r >= RW'(MSG_WORDS));
  end

endmodule

// File: rtl/hash_round_ctrl.sv
// SHA-2 compression sequencer: accepts message blocks over valid/ready,
// walks the round index, strobes the datapath and presents the digest.
module hash_round_ctrl #(
  parameter int ROUNDS    = hash_pkg::ROUNDS_SHA512,
  parameter int MSG_WORDS = hash_pkg::MSG_WORDS,
  parameter int RW        = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          blk_valid,
  output logic          blk_ready,
  input  logic          blk_first,
  input  logic          blk_last,
  output logic [RW-1:0] round,
  output logic          msg_we,
  output logic          sched_sel,
  output logic          dig_init,
  output logic          st_init,
  output logic          st_en,
  output logic          dig_acc,
  output logic          digest_valid,
  input  logic          digest_ready,
  output logic          busy
);

  import hash_pkg::*;

  state_t        state_r;
  state_t        state_nx_s;
  logic          in_msg_r;
  logic          last_r;
  logic          accept_s;
  logic          cnt_clr_s;
  logic          cnt_en_s;
  logic [RW-1:0] cnt_s;
  logic          cnt_last_s;
  logic          cnt_sched_s;

  // The counter only runs in ROUND and is held at zero everywhere else,
  // so round is already 0 on entry to ROUND.
  always_comb begin
    cnt_en_s  = (state_r == ST_ROUND);
    cnt_clr_s = (state_r != ST_ROUND) | cnt_last_s;
  end

  hash_round_cnt #(
    .ROUNDS    (ROUNDS),
    .MSG_WORDS (MSG_WORDS),
    .RW        (RW)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr_s),
    .en    (cnt_en_s),
    .cnt   (cnt_s),
    .last  (cnt_last_s),
    .sched (cnt_sched_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Message tracking: in_msg marks an open message for chaining, last_r
  // remembers whether the block in flight closes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_msg_r <= 1'b0;
      last_r   <= 1'b0;
    end else if (accept_s) begin
      in_msg_r <= 1'b1;
      last_r   <= blk_last;
    end else if ((state_r == ST_ACC) && last_r) begin
      in_msg_r <= 1'b0;
      last_r   <= last_r;
    end else begin
      in_msg_r <= in_msg_r;
      last_r   <= last_r;
    end
  end

  // Next-state and strobe decode; every output defaults low each cycle.
  always_comb begin
    state_nx_s   = state_r;
    accept_s     = 1'b0;
    blk_ready    = 1'b0;
    msg_we       = 1'b0;
    dig_init     = 1'b0;
    st_init      = 1'b0;
    st_en        = 1'b0;
    sched_sel    = 1'b0;
    round        = '0;
    dig_acc      = 1'b0;
    digest_valid = 1'b0;
    busy         = state_is_busy(state_r);
    case (state_r)
      ST_IDLE: begin
        blk_ready = 1'b1;
        if (blk_valid) begin
          accept_s   = 1'b1;
          msg_we     = 1'b1;
          // A fresh message (explicit or implied) loads the IV.
          dig_init   = blk_first | ~in_msg_r;
          state_nx_s = ST_INIT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_INIT: begin
        st_init    = 1'b1;
        state_nx_s = ST_ROUND;
      end
      ST_ROUND: begin
        st_en     = 1'b1;
        sched_sel = cnt_sched_s;
        round     = cnt_s;
        if (cnt_last_s) begin
          state_nx_s = ST_ACC;
        end else begin
          state_nx_s = ST_ROUND;
        end
      end
      ST_ACC: begin
        dig_acc = 1'b1;
        if (last_r) begin
          state_nx_s = ST_OUT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_OUT: begin
        digest_valid = 1'b1;
        if (digest_ready) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_OUT;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_hash_round_ctrl.sv
// Bench for hash_round_ctrl: an 80-round and a 64-round build share one
// input stream; each is compared every cycle against a phase-count model.
module tb_hash_round_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       blk_valid;
  logic       blk_first;
  logic       blk_last;
  logic       digest_ready;

  logic [1:0] blk_ready, msg_we, sched_sel, dig_init, st_init, st_en;
  logic [1:0] dig_acc, digest_valid, busy;
  logic [6:0] round0;
  logic [5:0] round1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state per build: ph = cycles since accept minus one
  // (-1 when no block in flight), ow = waiting for digest handshake.
  int rr[2]      = '{80, 64};
  int ph[2]      = '{-1, -1};
  bit ow[2]      = '{1'b0, 1'b0};
  bit mim[2]     = '{1'b0, 1'b0};
  bit ml[2]      = '{1'b0, 1'b0};
  int en_len[2]  = '{0, 0};
  int t_acc[2]   = '{0, 0};
  bit sprev[2]   = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  hash_round_ctrl #(.ROUNDS(80), .MSG_WORDS(16), .RW(7)) u_dut80 (
    .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_ready(blk_ready[0]),
    .blk_first(blk_first), .blk_last(blk_last), .round(round0),
    .msg_we(msg_we[0]), .sched_sel(sched_sel[0]), .dig_init(dig_init[0]),
    .st_init(st_init[0]), .st_en(st_en[0]), .dig_acc(dig_acc[0]),
    .digest_valid(digest_valid[0]), .digest_ready(digest_ready), .busy(busy[0])
  );

  hash_round_ctrl #(.ROUNDS(64), .MSG_WORDS(16), .RW(6)) u_dut64 (
    .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_ready(blk_ready[1]),
    .blk_first(blk_first), .blk_last(blk_last), .round(round1),
    .msg_we(msg_we[1]), .sched_sel(sched_sel[1]), .dig_init(dig_init[1]),
    .st_init(st_init[1]), .st_en(st_en[1]), .dig_acc(dig_acc[1]),
    .digest_valid(digest_valid[1]), .digest_ready(digest_ready), .busy(busy[1])
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Expected output vector for build i from the model and current inputs:
  // {ready, msg_we, sched, dig_init, st_init, st_en, dig_acc, dv, busy, round}
  function automatic logic [15:0] model_out(input int i);
    bit idle, acc, en;
    int rnd;
    idle = (ph[i] < 0) && !ow[i];
    acc  = idle && blk_valid;
    en   = (ph[i] >= 1) && (ph[i] <= rr[i]);
    rnd  = en ? ph[i] - 1 : 0;
    return {idle, acc, en && (rnd >= 16), acc && (blk_first || !mim[i]),
            ph[i] == 0, en, ph[i] == rr[i] + 1, ow[i], !idle, 7'(rnd)};
  endfunction

  task automatic model_update(input int i);
    bit idle;
    idle = (ph[i] < 0) && !ow[i];
    if (rst) begin
      ph[i] = -1; ow[i] = 1'b0; mim[i] = 1'b0; ml[i] = 1'b0;
    end else if (idle && blk_valid) begin
      ph[i] = 0; ml[i] = blk_last; mim[i] = 1'b1;
    end else if (ph[i] >= 0) begin
      if (ph[i] == rr[i] + 1) begin
        ph[i] = -1;
        if (ml[i]) begin
          ow[i] = 1'b1; mim[i] = 1'b0;
        end
      end else begin
        ph[i] = ph[i] + 1;
      end
    end else if (ow[i] && digest_ready) begin
      ow[i] = 1'b0;
    end
  endtask

  // One clock: compare just after inputs settle, then advance the models.
  task automatic step();
    logic [15:0] got;
    logic [6:0]  rnd;
    #2;
    for (int i = 0; i < 2; i++) begin
      rnd = (i == 0) ? round0 : {1'b0, round1};
      got = {blk_ready[i], msg_we[i], sched_sel[i], dig_init[i], st_init[i],
             st_en[i], dig_acc[i], digest_valid[i], busy[i], rnd};
      check((i == 0) ? "outs80" : "outs64", int'(got), int'(model_out(i)));
      if (rst) begin
        en_len[i] = 0;
      end else begin
        if (st_en[i]) en_len[i]++;
        if (dig_acc[i]) begin
          check("en_len", en_len[i], rr[i]);
          check("acc_lat", cyc - t_acc[i], rr[i] + 2);
          en_len[i] = 0;
        end
        if (msg_we[i]) t_acc[i] = cyc;
        if (sched_sel[i] && !sprev[i]) check("sched_rise", int'(rnd), 16);
      end
      sprev[i] = sched_sel[i];
    end
    @(posedge clk);
    model_update(0);
    model_update(1);
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_both_idle();
    int n = 0;
    blk_valid = 1'b0;
    while (blk_ready != 2'b11 && n < 300) begin
      step();
      n++;
    end
    check("idle_wait", int'(blk_ready == 2'b11), 1);
  endtask

  task automatic send(input bit f, input bit l);
    wait_both_idle();
    blk_valid = 1'b1; blk_first = f; blk_last = l;
    step();
    blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0;
  endtask

  initial begin
    rst = 1'b1; blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0;
    digest_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    step();
    rst = 1'b0;

    // Single-block message accepted at cycle 10, digest held unclaimed
    // while blk_valid toggles.
    while (cyc < 10) step();
    blk_valid = 1'b1; blk_first = 1'b1; blk_last = 1'b1;
    step();
    blk_first = 1'b0; blk_last = 1'b0;
    repeat (110) begin
      blk_valid = 1'($urandom_range(0, 1));
      step();
    end
    blk_valid = 1'b0;
    digest_ready = 1'b1;
    step();
    step();

    // Three-block message with the consumer always ready.
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b0, 1'b1);
    wait_both_idle();

    // Implied first block after reset, then a restart mid-message.
    rst = 1'b1;
    step();
    rst = 1'b0;
    send(1'b0, 1'b0);
    send(1'b1, 1'b1);
    wait_both_idle();

    // Reset during round 37 of the 80-round build, then a full block.
    send(1'b1, 1'b0);
    repeat (38) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    send(1'b1, 1'b1);
    wait_both_idle();

    // Random traffic with occasional reset.
    repeat (4000) begin
      rst          = ($urandom_range(0, 299) == 0);
      blk_valid    = ($urandom_range(0, 3) == 0);
      blk_first    = 1'($urandom_range(0, 1));
      blk_last     = 1'($urandom_range(0, 1));
      digest_ready = ($urandom_range(0, 2) == 0);
      step();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
